// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide unit holding the MIPS HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, sign fixup in FIN.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [1:0]  op_q;
    logic        neg_q;       // product/quotient must be negated
    logic        rneg_q;      // remainder must be negated (negative dividend)
    logic [31:0] a_raw;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] acc;

    logic        is_div;
    logic        is_signed;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [31:0] div_rem;
    logic [63:0] acc_nxt;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] fin_hi;
    logic [31:0] fin_lo;
    logic        fin_dz;

    assign is_div    = op_q[1];
    assign is_signed = ~op[0];
    assign a_abs     = (is_signed && operand_a[31]) ? (32'd0 - operand_a) : operand_a;
    assign b_abs     = (is_signed && operand_b[31]) ? (32'd0 - operand_b) : operand_b;

    // Multiply keeps the running product in acc, shifting right one bit per step.
    // Divide keeps {remainder, quotient} in acc, shifting left one bit per step.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (b_mag[cnt[4:0]] ? {1'b0, a_mag} : 33'd0);
        div_shift = {acc[63:32], a_mag[5'd31 - cnt[4:0]]};
        div_trial = div_shift - {1'b0, b_mag};
        div_rem   = div_trial[32] ? div_shift[31:0] : div_trial[31:0];
        if (is_div)
            acc_nxt = {div_rem, acc[30:0], ~div_trial[32]};
        else
            acc_nxt = {mul_sum, acc[31:1]};
    end

    always_comb begin
        prod   = (!op_q[0] && neg_q) ? (64'd0 - acc) : acc;
        quo    = (!op_q[0] && neg_q) ? (32'd0 - acc[31:0]) : acc[31:0];
        rem    = (!op_q[0] && rneg_q) ? (32'd0 - acc[63:32]) : acc[63:32];
        fin_dz = 1'b0;
        if (!is_div) begin
            fin_hi = prod[63:32];
            fin_lo = prod[31:0];
        end else if (b_mag == 32'd0) begin
            fin_hi = a_raw;
            fin_lo = 32'hFFFF_FFFF;
            fin_dz = 1'b1;
        end else begin
            fin_hi = rem;
            fin_lo = quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            op_q     <= 2'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            a_raw    <= 32'd0;
            a_mag    <= 32'd0;
            b_mag    <= 32'd0;
            acc      <= 64'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        op_q   <= op;
                        neg_q  <= is_signed & (operand_a[31] ^ operand_b[31]);
                        rneg_q <= is_signed & operand_a[31];
                        a_raw  <= operand_a;
                        a_mag  <= a_abs;
                        b_mag  <= b_abs;
                        acc    <= 64'd0;
                        cnt    <= 6'd0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIN;
                end
                FIN: begin
                    hi       <= fin_hi;
                    lo       <= fin_lo;
                    done     <= 1'b1;
                    div_zero <= fin_dz;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit: arithmetic reference model plus
// directed literal checks for the documented corner cases.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    mult_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // Reference arithmetic straight from the MIPS definitions.
    function automatic void calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic dz);
        longint      p, x, y, q, r;
        logic [63:0] u;
        dz = 1'b0;
        h  = 32'd0;
        l  = 32'd0;
        case (o)
            2'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                h = p[63:32];
                l = p[31:0];
            end
            2'd1: begin
                u = {32'd0, a} * {32'd0, b};
                h = u[63:32];
                l = u[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    h  = a;
                    l  = 32'hFFFF_FFFF;
                    dz = 1'b1;
                end else if (o == 2'd2) begin
                    x = longint'($signed(a));
                    y = longint'($signed(b));
                    q = x / y;
                    r = x % y;
                    h = r[31:0];
                    l = q[31:0];
                end else begin
                    h = a % b;
                    l = a / b;
                end
            end
        endcase
    endfunction

    // Model: an accepted op takes 33 further edges before its results land.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done, m_dz, p_dz;
    int          m_rem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0; m_dz = 1'b0; m_rem = 0;
            p_hi = 32'd0; p_lo = 32'd0; p_dz = 1'b0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dz = p_dz;
                end
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                if (start) begin
                    calc(op, operand_a, operand_b, p_hi, p_lo, p_dz);
                    m_rem = 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if ({hi, lo, busy, done, div_zero} !== {m_hi, m_lo, (m_rem != 0), m_done, m_dz}) begin
                fails++;
                $display("FAIL model_cmp t=%0t got hi=%h lo=%h busy=%b done=%b dz=%b expected hi=%h lo=%h busy=%b done=%b dz=%b",
                         $time, hi, lo, busy, done, div_zero, m_hi, m_lo, (m_rem != 0), m_done, m_dz);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge: launches an op and waits (bounded) for done.
    // junk drives ignored start/MTHI/MTLO traffic while the op is in flight.
    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit junk, output int lat);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            operand_a = $urandom; operand_b = $urandom; op = 2'($urandom);
            if (junk && k == 5) begin
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end else if (junk && k >= 2 && k <= 29) begin
                start = 1'($urandom); hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = $urandom;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            tests++; fails++;
            $display("FAIL done_timeout got none expected done within 40 cycles");
        end
    endtask

    initial begin
        int lat;
        int stray;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);

        run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        chk("multu_latency", 32'(lat), 32'd34);

        run(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, lat);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);
        run(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, lat);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        run(2'd3, 32'h0000_002A, 32'd0, 1'b0, lat);
        chk("divz_lo", lo, 32'hFFFF_FFFF);
        chk("divz_hi", hi, 32'h0000_002A);
        chk("divz_flag", {31'd0, div_zero}, 32'd1);
        run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);
        chk("divovf_flag", {31'd0, div_zero}, 32'd0);

        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
        chk("mthi", hi, 32'h1234_5678);
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", lo, 32'h9ABC_DEF0);
        chk("mthi_hold", hi, 32'h1234_5678);

        run(2'd3, 32'd100, 32'd7, 1'b1, lat);
        chk("busywr_lo", lo, 32'd14);
        chk("busywr_hi", hi, 32'd2);
        run(2'd1, 32'd5, 32'd6, 1'b1, lat);
        chk("ignstart_lo", lo, 32'd30);
        chk("ignstart_hi", hi, 32'd0);
        // launched in the done cycle of the previous op
        run(2'd1, 32'd3, 32'd4, 1'b0, lat);
        chk("b2b_lo", lo, 32'd12);
        chk("b2b_latency", 32'(lat), 32'd34);

        start = 1'b1; op = 2'd3; operand_a = 32'd1000; operand_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_flags", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) stray++;
        end
        chk("midrst_stray_done", 32'(stray), 32'd0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = $urandom;
                @(negedge clk);
                hi_we = 1'b0; lo_we = 1'b0;
            end
            run(2'($urandom), rand_opnd(), rand_opnd(), 1'($urandom), lat);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got no finish expected finish before 1ms");
        $fatal(1);
    end

endmodule
